// File: rtl/ad7960_emu.sv
// ad7960_emu: ADC-side responder for the AD7960 echoed-clock serial interface.
// Latches one word per CNV rise and returns it MSB-first on d_o, with the
// controller's gated clock echoed on dco_o.
// Build option: define AD7960_EMU_TEST_PATTERN_EN to replace sample_i with an
// internal ramp counter (sample_ready_o and underrun_o then stay 0).
`timescale 1ns/1ps
module ad7960_emu #(
  parameter int DATA_W      = 18,
  parameter int TMSB_CYC    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              m_clk_i,
  input  logic              reset_n_i,
  input  logic              cnv_i,
  input  logic              sclk_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  output logic              sample_ready_o,
  output logic              d_o,
  output logic              dco_o,
  output logic              busy_o,
  output logic              underrun_o,
  output logic              abort_o
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int TMSB_W = $clog2(TMSB_CYC + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_READ    = 2'd2;

  logic [SYNC_STAGES-1:0] r_cnvSync;
  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic                   r_cnvHist;
  logic                   r_sclkHist;
  logic [1:0]             r_state;
  logic [DATA_W-1:0]      r_hold;
  logic [DATA_W-1:0]      r_shreg;
  logic [CNT_W-1:0]       r_bitCnt;
  logic [TMSB_W-1:0]      r_tmsbCnt;
  logic                   r_d;
  logic                   r_dco;
  logic                   r_busy;
  logic                   r_ready;
  logic                   r_underrun;
  logic                   r_abort;

  logic                   w_cnvRise;
  logic                   w_sclkRise;
  logic                   w_sclkFall;
  logic [DATA_W-1:0]      w_nextWord;
  logic                   w_wordValid;
  logic                   w_reportHandshake;

`ifdef AD7960_EMU_TEST_PATTERN_EN
  logic [DATA_W-1:0] r_ramp;

  // Ramp source: the word for each frame is the count of CNV rises since reset.
  always_ff @(posedge m_clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      r_ramp <= '0;
    else if (w_cnvRise)
      r_ramp <= r_ramp + 1'b1;
  end

  assign w_nextWord        = r_ramp;
  assign w_wordValid       = 1'b1;
  assign w_reportHandshake = 1'b0;
`else
  assign w_nextWord        = sample_i;
  assign w_wordValid       = sample_valid_i;
  assign w_reportHandshake = 1'b1;
`endif

  // Resynchronise the asynchronous controller strobes and keep one history bit for edge detection.
  always_ff @(posedge m_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnvSync  <= '0;
      r_sclkSync <= '0;
      r_cnvHist  <= 1'b0;
      r_sclkHist <= 1'b0;
    end else begin
      r_cnvSync  <= {r_cnvSync[SYNC_STAGES-2:0], cnv_i};
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], sclk_i};
      r_cnvHist  <= r_cnvSync[SYNC_STAGES-1];
      r_sclkHist <= r_sclkSync[SYNC_STAGES-1];
    end
  end

  assign w_cnvRise  =  r_cnvSync[SYNC_STAGES-1]  & ~r_cnvHist;
  assign w_sclkRise =  r_sclkSync[SYNC_STAGES-1] & ~r_sclkHist;
  assign w_sclkFall = ~r_sclkSync[SYNC_STAGES-1] &  r_sclkHist;

  // Frame sequencer: a CNV rise restarts everything; otherwise CONVERT waits out tMSB
  // and READ shifts one bit per accepted sclk pulse. A fall only shifts when it closes
  // a pulse whose rise was echoed, so stray falls never advance the word.
  always_ff @(posedge m_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_shreg    <= '0;
      r_bitCnt   <= '0;
      r_tmsbCnt  <= '0;
      r_d        <= 1'b0;
      r_dco      <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_ready    <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
      r_busy     <= (r_state != S_IDLE);
      if (w_cnvRise) begin
        if (w_wordValid)
          r_hold <= w_nextWord;
        r_ready    <= w_wordValid & w_reportHandshake;
        r_underrun <= ~w_wordValid & w_reportHandshake;
        r_abort    <= (r_state == S_READ) && (r_bitCnt != '0);
        r_state    <= S_CONVERT;
        r_tmsbCnt  <= TMSB_W'(TMSB_CYC - 1);
        r_dco      <= 1'b0;
        r_d        <= 1'b0;
      end else begin
        case (r_state)
          S_CONVERT: begin
            r_dco <= 1'b0;
            if (r_tmsbCnt == '0) begin
              r_state  <= S_READ;
              r_shreg  <= r_hold;
              r_d      <= r_hold[DATA_W-1];
              r_bitCnt <= CNT_W'(DATA_W);
            end else begin
              r_tmsbCnt <= r_tmsbCnt - 1'b1;
            end
          end
          S_READ: begin
            if (w_sclkRise && (r_bitCnt != '0)) begin
              r_dco    <= 1'b1;
              r_bitCnt <= r_bitCnt - 1'b1;
            end else if (w_sclkFall && r_dco) begin
              r_dco <= 1'b0;
              if (r_bitCnt == '0) begin
                r_d     <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_shreg <= r_shreg << 1;
                r_d     <= r_shreg[DATA_W-2];
              end
            end
          end
          default: begin
            r_d   <= 1'b0;
            r_dco <= 1'b0;
          end
        endcase
      end
    end
  end

  assign d_o            = r_d;
  assign dco_o          = r_dco;
  assign busy_o         = r_busy;
  assign sample_ready_o = r_ready;
  assign underrun_o     = r_underrun;
  assign abort_o        = r_abort;

endmodule

// File: tb/tb_ad7960_emu.sv
// tb_ad7960_emu: directed self-checking bench for ad7960_emu.
// Frames are captured from d_o on each dco_o rising edge; pulse outputs are counted
// on the falling system clock edge and checked as deltas around each stimulus.
// The DUT uses a long tMSB window so sclk pulses can be placed inside CONVERT.
`timescale 1ns/1ps
module tb_ad7960_emu;

  localparam int DATA_W = 18;
  localparam int TMSB   = 40;

  logic              clock;
  logic              reset_n;
  logic              cnv;
  logic              sclk;
  logic [DATA_W-1:0] sample;
  logic              sampleValid;
  logic              sampleReady;
  logic              dOut;
  logic              dco;
  logic              busy;
  logic              underrun;
  logic              abortPulse;

  int checkCount = 0;
  int failCount  = 0;

  logic [DATA_W-1:0] rxWord = '0;
  int rxCount       = 0;
  int readyCount    = 0;
  int underrunCount = 0;
  int abortCount    = 0;

  ad7960_emu #(.DATA_W(DATA_W), .TMSB_CYC(TMSB), .SYNC_STAGES(2)) dut (
    .m_clk_i        (clock),
    .reset_n_i      (reset_n),
    .cnv_i          (cnv),
    .sclk_i         (sclk),
    .sample_i       (sample),
    .sample_valid_i (sampleValid),
    .sample_ready_o (sampleReady),
    .d_o            (dOut),
    .dco_o          (dco),
    .busy_o         (busy),
    .underrun_o     (underrun),
    .abort_o        (abortPulse)
  );

  // 100 MHz system clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Capture serial data on the echoed clock, the way a controller would
  always @(posedge dco) begin
    rxWord  = {rxWord[DATA_W-2:0], dOut};
    rxCount = rxCount + 1;
  end

  // Count 1-cycle status pulses away from the active edge
  always @(negedge clock) begin
    if (sampleReady) readyCount    = readyCount + 1;
    if (underrun)    underrunCount = underrunCount + 1;
    if (abortPulse)  abortCount    = abortCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Convert strobe held long enough to be seen, then wait past the tMSB window
  task automatic applyCnv();
    cnv = 1'b1;
    repeat (6) @(posedge clock);
    cnv = 1'b0;
    repeat (TMSB + 4) @(posedge clock);
  endtask

  // sclk pulses at clock/8, well inside the clock/4 limit
  task automatic applySclk(input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1;
      repeat (4) @(posedge clock);
      sclk = 1'b0;
      repeat (4) @(posedge clock);
    end
  endtask

  // Full frame: convert, clock out DATA_W bits, check the captured word and bit count
  task automatic applyStimulus(input string tag, input logic [DATA_W-1:0] expected);
    int startCount;
    startCount = rxCount;
    applyCnv();
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    applySclk(DATA_W);
    repeat (8) @(posedge clock);
    checkOutput({tag, "_word"}, 32'(rxWord), 32'(expected));
    checkOutput({tag, "_bits"}, 32'(rxCount - startCount), 32'(DATA_W));
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int r0, u0, a0, c0;
    reset_n     = 1'b0;
    cnv         = 1'b0;
    sclk        = 1'b0;
    sample      = '0;
    sampleValid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_d",     32'(dOut),        32'd0);
    checkOutput("rst_dco",   32'(dco),         32'd0);
    checkOutput("rst_busy",  32'(busy),        32'd0);
    checkOutput("rst_ready", 32'(sampleReady), 32'd0);
    checkOutput("rst_under", 32'(underrun),    32'd0);
    checkOutput("rst_abort", 32'(abortPulse),  32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(posedge clock);

`ifdef AD7960_EMU_TEST_PATTERN_EN
    applyStimulus("ramp0", 18'h00000);
    applyStimulus("ramp1", 18'h00001);
    applyStimulus("ramp2", 18'h00002);
    checkOutput("ramp_ready", 32'(readyCount), 32'd0);
`else
    // Valid sample, alternating pattern
    r0 = readyCount; u0 = underrunCount;
    sample = 18'h2AAAA; sampleValid = 1'b1;
    applyStimulus("t1", 18'h2AAAA);
    checkOutput("t1_ready", 32'(readyCount - r0), 32'd1);
    checkOutput("t1_under", 32'(underrunCount - u0), 32'd0);

    // No valid sample: previous word is resent
    r0 = readyCount; u0 = underrunCount;
    sample = 18'h15555; sampleValid = 1'b0;
    applyStimulus("t2", 18'h2AAAA);
    checkOutput("t2_under", 32'(underrunCount - u0), 32'd1);
    checkOutput("t2_ready", 32'(readyCount - r0), 32'd0);

    // Abort a frame after 7 bits of all-ones, restart with 00001
    a0 = abortCount;
    sample = 18'h3FFFF; sampleValid = 1'b1;
    applyCnv();
    applySclk(7);
    checkOutput("t3_noabort", 32'(abortCount - a0), 32'd0);
    sample = 18'h00001;
    applyStimulus("t3", 18'h00001);
    checkOutput("t3_abort", 32'(abortCount - a0), 32'd1);

    // sclk pulses during CONVERT are ignored
    sample = 18'h1C3A5;
    c0 = rxCount;
    cnv = 1'b1;
    repeat (6) @(posedge clock);
    applySclk(3);
    cnv = 1'b0;
    checkOutput("t4_nodco", 32'(rxCount - c0), 32'd0);
    repeat (30) @(posedge clock);
    applySclk(DATA_W);
    repeat (8) @(posedge clock);
    checkOutput("t4_word", 32'(rxWord), 32'h1C3A5);
    checkOutput("t4_bits", 32'(rxCount - c0), 32'(DATA_W));

    // Reset in the middle of bit 9 while dco_o is high
    sample = 18'h3FFFF;
    applyCnv();
    applySclk(8);
    sclk = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checkOutput("t5_pre_dco", 32'(dco),  32'd1);
    checkOutput("t5_pre_d",   32'(dOut), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("t5_rst_d",    32'(dOut), 32'd0);
    checkOutput("t5_rst_dco",  32'(dco),  32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    sclk = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    u0 = underrunCount;
    sampleValid = 1'b0;
    applyStimulus("t5", 18'h00000);
    checkOutput("t5_under", 32'(underrunCount - u0), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
